// File: rtl/mult_pkg.sv
// mult_pkg -- shared constants and helpers for the pipelined Braun multiplier.
//   Operand width limits, partial-product row partitioning across pipeline
//   stages, and the Baugh-Wooley correction constant.
package mult_pkg;

  localparam int MULT_MIN_WIDTH  = 2;
  localparam int MULT_MAX_WIDTH  = 32;
  localparam int MULT_MIN_STAGES = 1;

  // Rows handled by every stage except possibly the last, which takes the remainder.
  function automatic int rows_per_stage(input int width, input int stages);
    return (width + stages - 1) / stages;
  endfunction

  // Index of the first partial-product row handled by a stage.
  function automatic int stage_row_start(input int stage, input int width, input int stages);
    return stage * rows_per_stage(width, stages);
  endfunction

  // Number of rows actually present in a stage (may be zero for trailing stages).
  function automatic int stage_row_count(input int stage, input int width, input int stages);
    int first;
    int per;
    first = stage_row_start(stage, width, stages);
    per   = rows_per_stage(width, stages);
    if (first >= width) return 0;
    if (first + per > width) return width - first;
    return per;
  endfunction

  // Stage that owns a given partial-product row.
  function automatic int row_stage(input int row, input int width, input int stages);
    return row / rows_per_stage(width, stages);
  endfunction

  // Modified Baugh-Wooley correction: +2^W + 2^(2W-1), taken modulo 2^(2W).
  function automatic logic [63:0] bw_correction(input int width);
    logic [63:0] c;
    c = '0;
    c[width]         = 1'b1;
    c[2 * width - 1] = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/braun_row.sv
// braun_row -- one carry-save adder row of the Braun array.
//   Forms partial-product row ROW (a & b_bit, shifted by ROW) and compresses
//   it into the incoming sum/carry pair. In signed mode the cross terms that
//   involve exactly one operand sign bit are inverted (Baugh-Wooley).
// Ports:
//   a           multiplicand
//   b_bit       multiplier bit ROW
//   signed_mode 1 = two's complement operands
//   sum_in/carry_in    redundant partial sum entering the row
//   sum_out/carry_out  redundant partial sum leaving the row
module braun_row
  import mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ROW   = 0
) (
  input  logic [WIDTH-1:0]   a,
  input  logic               b_bit,
  input  logic               signed_mode,
  input  logic [2*WIDTH-1:0] sum_in,
  input  logic [2*WIDTH-1:0] carry_in,
  output logic [2*WIDTH-1:0] sum_out,
  output logic [2*WIDTH-1:0] carry_out
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0] pp_row;
  logic [PW-1:0] maj;

  always_comb begin
    pp_row = '0;
    for (int j = 0; j < WIDTH; j++) begin
      // Invert only where exactly one of the two bits is a sign bit.
      pp_row[ROW + j] = (a[j] & b_bit) ^
                        (signed_mode & ((ROW == WIDTH - 1) != (j == WIDTH - 1)));
    end
  end

  assign sum_out = sum_in ^ carry_in ^ pp_row;
  assign maj     = (sum_in & carry_in) | (sum_in & pp_row) | (carry_in & pp_row);
  // Carry out of the top bit falls outside the 2*WIDTH product and is dropped.
  assign carry_out = maj << 1;

endmodule

// File: rtl/pipelined_braun_multiplier.sv
// pipelined_braun_multiplier -- STAGES-deep pipelined Braun array multiplier
//   with per-operand unsigned / Baugh-Wooley signed selection and a
//   valid/ready handshake on both sides.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  operand handshake (a, b, signed_mode)
//   out_valid/out_ready product handshake (p, 2*WIDTH bits)
// Partial-product rows are spread over the stages, ceil(WIDTH/STAGES) per
// stage; the final carry-propagate add happens in the last stage, whose
// register is the output p. A stalled output freezes the whole pipe.
module pipelined_braun_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int PW  = 2 * WIDTH;
  localparam int RPS = rows_per_stage(WIDTH, STAGES);

  logic adv;

  // Values entering each stage: index 0 comes from the ports, index s>0
  // from the register of stage s-1.
  logic [STAGES-1:0] vld_in;
  logic [PW-1:0]     sum_in   [STAGES];
  logic [PW-1:0]     carry_in [STAGES];
  logic [WIDTH-1:0]  a_in     [STAGES];
  logic [WIDTH-1:0]  b_in     [STAGES];
  logic              mode_in  [STAGES];

  // Global stall: every stage, bubbles included, holds while p is blocked.
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv && !rst;

  assign vld_in[0]   = in_valid && in_ready;
  assign sum_in[0]   = signed_mode ? PW'(bw_correction(WIDTH)) : '0;
  assign carry_in[0] = '0;
  assign a_in[0]     = a;
  assign b_in[0]     = b;
  assign mode_in[0]  = signed_mode;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int ROW0 = stage_row_start(s, WIDTH, STAGES);
    localparam int NROW = stage_row_count(s, WIDTH, STAGES);

    logic [PW-1:0] sum_c   [RPS+1];
    logic [PW-1:0] carry_c [RPS+1];

    assign sum_c[0]   = sum_in[s];
    assign carry_c[0] = carry_in[s];

    for (genvar r = 0; r < RPS; r++) begin : g_row
      if (r < NROW) begin : g_add
        braun_row #(
          .WIDTH (WIDTH),
          .ROW   (ROW0 + r)
        ) u_row (
          .a           (a_in[s]),
          .b_bit       (b_in[s][ROW0 + r]),
          .signed_mode (mode_in[s]),
          .sum_in      (sum_c[r]),
          .carry_in    (carry_c[r]),
          .sum_out     (sum_c[r+1]),
          .carry_out   (carry_c[r+1])
        );
      end else begin : g_pass
        assign sum_c[r+1]   = sum_c[r];
        assign carry_c[r+1] = carry_c[r];
      end
    end

    if (s < STAGES - 1) begin : g_reg
      // ---- stage s register boundary (redundant partial sum) ----
      logic             vld_q;
      logic [PW-1:0]    sum_q;
      logic [PW-1:0]    carry_q;
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic             mode_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= 1'b0;
        end else if (adv) begin
          vld_q <= vld_in[s];
        end
      end

      always_ff @(posedge clk) begin
        if (adv) begin
          sum_q   <= sum_c[RPS];
          carry_q <= carry_c[RPS];
          a_q     <= a_in[s];
          b_q     <= b_in[s];
          mode_q  <= mode_in[s];
        end
      end

      assign vld_in[s+1]   = vld_q;
      assign sum_in[s+1]   = sum_q;
      assign carry_in[s+1] = carry_q;
      assign a_in[s+1]     = a_q;
      assign b_in[s+1]     = b_q;
      assign mode_in[s+1]  = mode_q;
    end else begin : g_out
      // ---- final stage boundary: carry-propagate add into p ----
      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid <= 1'b0;
          p         <= '0;
        end else if (adv) begin
          out_valid <= vld_in[s];
          p         <= sum_c[RPS] + carry_c[RPS];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_braun_multiplier.sv
// Self-checking bench for pipelined_braun_multiplier: a default 8x8/4-stage
// instance and a 4x4/2-stage instance, directed tables plus random sweeps
// scored against an arithmetic reference.
module tb_pipelined_braun_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        in_valid8 = 1'b0, out_ready8 = 1'b1, mode8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        in_ready8, out_valid8;
  logic [15:0] p8;

  logic        in_valid4 = 1'b0, out_ready4 = 1'b1, mode4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        in_ready4, out_valid4;
  logic [7:0]  p4;

  always #5 clk = ~clk;

  pipelined_braun_multiplier #(.WIDTH(8), .STAGES(4)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .signed_mode(mode8),
    .out_valid(out_valid8), .out_ready(out_ready8), .p(p8)
  );

  pipelined_braun_multiplier #(.WIDTH(4), .STAGES(2)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .signed_mode(mode4),
    .out_valid(out_valid4), .out_ready(out_ready4), .p(p4)
  );

  typedef struct {
    logic [15:0] p;
    int          acc;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    bit         m;
    logic [7:0] p;
  } vec4_t;

  exp_t q8[$];
  exp_t q4[$];
  int tests = 0, fails = 0, cyc = 0, pops8 = 0, pops4 = 0;
  bit lat8 = 0, lat4 = 0, stall8_prev = 0, stall4_prev = 0;
  logic [15:0] p8_prev;
  logic [7:0]  p4_prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input bit m);
    longint xa, ya;
    xa = m ? longint'($signed(x)) : longint'(x);
    ya = m ? longint'($signed(y)) : longint'(y);
    return 16'(xa * ya);
  endfunction

  function automatic logic [7:0] ref4(input logic [3:0] x, input logic [3:0] y, input bit m);
    longint xa, ya;
    xa = m ? longint'($signed(x)) : longint'(x);
    ya = m ? longint'($signed(y)) : longint'(y);
    return 8'(xa * ya);
  endfunction

  // One clock of the 8-bit instance: drive at negedge, sample 1 ns later.
  task automatic cyc8(input bit iv, input logic [7:0] av, input logic [7:0] bv, input bit m,
                      input bit ordy, input bit r, input logic [15:0] ev);
    exp_t e;
    @(negedge clk);
    rst = r; in_valid8 = iv; a8 = av; b8 = bv; mode8 = m; out_ready8 = ordy;
    in_valid4 = 1'b0; out_ready4 = 1'b1;
    #1;
    if (stall8_prev) begin
      chk("hold_valid8", out_valid8, 1);
      chk("hold_p8", p8, p8_prev);
    end
    chk("in_ready8", in_ready8, 32'(!r && !(out_valid8 && !ordy)));
    if (q8.size() == 0) begin
      chk("spurious_valid8", out_valid8, 0);
    end else if (out_valid8 && ordy) begin
      e = q8.pop_front();
      pops8++;
      chk("p8", p8, e.p);
      if (lat8) chk("latency8", cyc - e.acc, 4);
    end
    stall8_prev = out_valid8 && !ordy && !r;
    p8_prev = p8;
    if (iv && in_ready8) q8.push_back('{p: ev, acc: cyc});
    if (r) q8.delete();
    cyc++;
  endtask

  task automatic cyc4(input bit iv, input logic [3:0] av, input logic [3:0] bv, input bit m,
                      input bit ordy, input logic [7:0] ev);
    exp_t e;
    @(negedge clk);
    rst = 1'b0; in_valid4 = iv; a4 = av; b4 = bv; mode4 = m; out_ready4 = ordy;
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    #1;
    if (stall4_prev) begin
      chk("hold_valid4", out_valid4, 1);
      chk("hold_p4", p4, p4_prev);
    end
    chk("in_ready4", in_ready4, 32'(!(out_valid4 && !ordy)));
    if (q4.size() == 0) begin
      chk("spurious_valid4", out_valid4, 0);
    end else if (out_valid4 && ordy) begin
      e = q4.pop_front();
      pops4++;
      chk("p4", p4, e.p);
      if (lat4) chk("latency4", cyc - e.acc, 2);
    end
    stall4_prev = out_valid4 && !ordy;
    p4_prev = p4;
    if (iv && in_ready4) q4.push_back('{p: 16'(ev), acc: cyc});
    cyc++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec4_t tbl[8];
    logic [7:0] ra, rb;
    logic [3:0] sa, sb;
    bit rm, riv, rordy, saw_low;
    int target, guard;

    tbl[0] = '{4'd6,  4'd3,  1'b0, 8'd18};
    tbl[1] = '{4'd8,  4'd3,  1'b0, 8'd24};
    tbl[2] = '{4'd9,  4'd8,  1'b0, 8'd72};
    tbl[3] = '{4'd10, 4'd13, 1'b0, 8'd130};
    tbl[4] = '{4'd14, 4'd13, 1'b0, 8'd182};
    tbl[5] = '{4'hE,  4'hD,  1'b1, 8'h06};
    tbl[6] = '{4'h8,  4'h8,  1'b1, 8'h40};
    tbl[7] = '{4'h7,  4'h8,  1'b1, 8'hC8};

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_in_ready8", in_ready8, 0);
    chk("rst_out_valid8", out_valid8, 0);
    chk("rst_p8", p8, 0);
    chk("rst_in_ready4", in_ready4, 0);
    chk("rst_out_valid4", out_valid4, 0);
    chk("rst_p4", p4, 0);

    cyc8(0, 8'h00, 8'h00, 0, 1, 0, 16'h0000);
    chk("ready_after_rst8", in_ready8, 1);

    // 4x4, two stages: table, back-to-back
    lat4 = 1;
    for (int i = 0; i < 8; i++) cyc4(1, tbl[i].a, tbl[i].b, tbl[i].m, 1, tbl[i].p);
    repeat (4) cyc4(0, 4'h0, 4'h0, 0, 1, 8'h00);
    lat4 = 0;

    // 8x8 boundaries and alternating mode
    lat8 = 1;
    cyc8(1, 8'h80, 8'h80, 1, 1, 0, 16'h4000);
    cyc8(1, 8'hFF, 8'hFF, 0, 1, 0, 16'hFE01);
    for (int i = 0; i < 6; i++)
      cyc8(1, 8'hFF, 8'h02, bit'(i % 2), 1, 0, (i % 2) ? 16'hFFFE : 16'h01FE);
    repeat (6) cyc8(0, 8'h00, 8'h00, 0, 1, 0, 16'h0000);

    // Stall with streaming input: out_ready low for 6 cycles once full
    lat8 = 0;
    saw_low = 0;
    for (int i = 0; i < 14; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rm = bit'($urandom_range(0, 1));
      cyc8(i < 12, ra, rb, rm, i >= 10, 0, ref8(ra, rb, rm));
      if (!in_ready8) saw_low = 1;
    end
    repeat (8) cyc8(0, 8'h00, 8'h00, 0, 1, 0, 16'h0000);
    chk("in_ready_fell", saw_low, 1);
    chk("stall_drained", q8.size(), 0);

    // Reset with three products in flight
    lat8 = 1;
    cyc8(1, 8'd3, 8'd5, 0, 1, 0, 16'd15);
    cyc8(1, 8'd7, 8'd9, 0, 1, 0, 16'd63);
    cyc8(1, 8'hF0, 8'h11, 1, 1, 0, ref8(8'hF0, 8'h11, 1));
    cyc8(0, 8'h00, 8'h00, 0, 1, 1, 16'h0000);
    chk("rst_mid_out_valid", out_valid8, 0);
    repeat (4) cyc8(0, 8'h00, 8'h00, 0, 1, 0, 16'h0000);
    cyc8(1, 8'd12, 8'd11, 0, 1, 0, 16'd132);
    repeat (6) cyc8(0, 8'h00, 8'h00, 0, 1, 0, 16'h0000);
    chk("post_rst_delivered", pops8 > 0 && q8.size() == 0, 1);
    lat8 = 0;

    // Random sweep, 8x8
    target = pops8 + 10000;
    guard = 0;
    while (pops8 < target && guard < 30000) begin
      ra = 8'($urandom); rb = 8'($urandom); rm = bit'($urandom_range(0, 1));
      riv = ($urandom_range(0, 3) != 0);
      rordy = ($urandom_range(0, 9) < 7);
      cyc8(riv, ra, rb, rm, rordy, 0, ref8(ra, rb, rm));
      guard++;
    end
    chk("random8_completed", pops8 >= target, 1);
    for (int k = 0; k < 50 && q8.size() > 0; k++) cyc8(0, 8'h00, 8'h00, 0, 1, 0, 16'h0000);
    chk("random8_drained", q8.size(), 0);

    // Random sweep, 4x4
    target = pops4 + 2000;
    guard = 0;
    while (pops4 < target && guard < 6000) begin
      sa = 4'($urandom); sb = 4'($urandom); rm = bit'($urandom_range(0, 1));
      riv = ($urandom_range(0, 3) != 0);
      rordy = ($urandom_range(0, 9) < 6);
      cyc4(riv, sa, sb, rm, rordy, ref4(sa, sb, rm));
      guard++;
    end
    chk("random4_completed", pops4 >= target, 1);
    for (int k = 0; k < 50 && q4.size() > 0; k++) cyc4(0, 4'h0, 4'h0, 0, 1, 8'h00);
    chk("random4_drained", q4.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipelined_braun_multiplier.md
PIPELINED_BRAUN_MULTIPLIER -- requirements
Module: pipelined_braun_multiplier

Interface
REQ-001 Parameter WIDTH, default 8, is the operand width in bits; legal range 2..32.
REQ-002 Parameter STAGES, default 4, is the number of pipeline register stages; legal range 1..WIDTH.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand pair presented.
REQ-006 in_ready  output  1  block accepts an operand pair this cycle.
REQ-007 a  input  WIDTH  multiplicand.
REQ-008 b  input  WIDTH  multiplier.
REQ-009 signed_mode  input  1  1 = two's-complement operands; 0 = unsigned operands; sampled with a and b.
REQ-010 out_valid  output  1  p holds a valid product.
REQ-011 out_ready  input  1  downstream consumer accepts p.
REQ-012 p  output  2*WIDTH  product.

Function
REQ-013 The block shall accept an operand pair on any rising edge where in_valid and in_ready are both 1.
REQ-014 The block shall compute p = a*b exactly in 2*WIDTH bits: zero-extended when signed_mode=0, Baugh-Wooley two's complement when signed_mode=1.
REQ-015 Partial-product rows shall be split across STAGES register stages with ceil(WIDTH/STAGES) rows per stage; the last stage shall hold any remainder rows.
REQ-016 Each stage shall carry a valid bit, its partial sum, the remaining operand bits and the signed_mode flag.
REQ-017 With no stall, latency shall be exactly STAGES cycles from acceptance to out_valid=1, at a throughput of one product per cycle.
REQ-018 A global stall shall apply when out_valid=1 and out_ready=0: all stages hold, and p and out_valid remain stable.
REQ-019 in_ready shall equal NOT(out_valid AND NOT out_ready) AND NOT rst.
REQ-020 Empty (invalid) stages shall advance as bubbles; bubbles shall not be compressed during a stall.
REQ-021 A product shall be consumed on an edge where out_valid and out_ready are both 1; if the next stage holds data, it shall appear on the same edge with no bubble inserted.
REQ-022 When a transfer out and a transfer in occur in the same cycle, both shall complete.
REQ-023 signed_mode may change on every accepted pair; each product shall use its own captured mode.
REQ-024 Boundary: with signed_mode=1, a = b = most-negative value shall yield +2^(2*WIDTH-2) without overflow.
REQ-025 Boundary: with signed_mode=0, a = b = all-ones shall yield (2^WIDTH-1)^2.
REQ-026 When STAGES=1, the block shall behave as a single registered array multiplier with latency 1.

Reset
REQ-027 While rst=1, all stage valid bits, out_valid and p shall be cleared to 0, and in_ready shall be 0.
REQ-028 Reset asserted mid-operation shall discard every in-flight product; no out_valid pulse shall occur for operands accepted before the reset.
REQ-029 in_ready shall be 1 in the first cycle after rst deasserts.

Structure
REQ-030 Per-stage row count and stage-index helpers shall live in a shared package, mult_pkg, alongside the existing multiplier constants.
REQ-031 One sub-module, braun_row (one carry-save adder row with optional Baugh-Wooley inversion), shall be instantiated per partial-product row.
REQ-032 Final carry-propagate addition shall occur in the last stage.

Verification
REQ-033 WIDTH=4, STAGES=2, unsigned: (6,3), (8,3), (9,8), (10,13), (14,13) back-to-back with out_ready=1 -> p = 18, 24, 72, 130, 182 on consecutive cycles, the first one 2 cycles after acceptance.
REQ-034 WIDTH=4, signed_mode=1: a=4'hE, b=4'hD -> p=8'h06; a=4'h8, b=4'h8 -> p=8'h40; a=4'h7, b=4'h8 -> p=8'hC8.
REQ-035 Defaults (WIDTH=8, STAGES=4): hold out_ready=0 for 6 cycles while streaming -> in_ready falls once the pipe is full, no product lost or duplicated, and order is preserved on release.
REQ-036 Alternate signed_mode per beat with a=8'hFF, b=8'h02 -> p alternates 16'h01FE (unsigned) and 16'hFFFE (signed).
REQ-037 Assert rst for 1 cycle with 3 products in flight -> out_valid stays 0 until new operands are accepted, and the first new result appears exactly STAGES cycles after acceptance.
REQ-038 Randomised sweep over both modes with random out_ready, checked against a reference multiplier -> zero mismatches over 10,000 products.
